// File: rtl/syndrome_stream_host_pkg.sv
// Shared constants for the host side of the decoder byte link: message bytes,
// host FSM state encoding and the lattice-size helper functions.
package syndrome_stream_host_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND_START  = 3'd1;
    localparam logic [2:0] ST_SEND_HEADER = 3'd2;
    localparam logic [2:0] ST_LOAD_ROUND  = 3'd3;
    localparam logic [2:0] ST_SEND_ROUND  = 3'd4;
    localparam logic [2:0] ST_RECV_HDR    = 3'd5;
    localparam logic [2:0] ST_RECV_CORR   = 3'd6;
    localparam logic [2:0] ST_PRESENT     = 3'd7;

    function automatic int unsigned ceil_div8(input int unsigned n);
        return (n + 7) / 8;
    endfunction

    function automatic int unsigned corr_width(input int unsigned x, input int unsigned z);
        return 2 * (x - 1) * z + 1 + x * z;
    endfunction

    localparam int unsigned DEF_ALIGNED_PU  = 8 * ceil_div8(4 * 1);
    localparam int unsigned DEF_CORR_WIDTH  = corr_width(4, 1);

endpackage

// File: rtl/syndrome_stream_host_if.sv
// Bundle of the four valid/ready channels between the host endpoint and its
// local measurement source / controller link / result consumer.
interface syndrome_stream_host_if
    import syndrome_stream_host_pkg::*;
#(
    parameter int unsigned MEAS_W = DEF_ALIGNED_PU,
    parameter int unsigned CORR_W = DEF_CORR_WIDTH
) ();

    logic [MEAS_W-1:0] meas_data;
    logic              meas_valid;
    logic              meas_ready;

    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;

    logic [7:0]        res_iterations;
    logic [15:0]       res_cycles;
    logic [CORR_W-1:0] res_correction;
    logic              res_valid;
    logic              res_ready;
    logic              res_last;

    modport master (
        input  meas_data, meas_valid, tx_ready, rx_data, rx_valid, res_ready,
        output meas_ready, tx_data, tx_valid, rx_ready,
        output res_iterations, res_cycles, res_correction, res_valid, res_last
    );

    modport slave (
        output meas_data, meas_valid, tx_ready, rx_data, rx_valid, res_ready,
        input  meas_ready, tx_data, tx_valid, rx_ready,
        input  res_iterations, res_cycles, res_correction, res_valid, res_last
    );

endinterface

// File: rtl/syndrome_stream_host_byte_deserializer.sv
// Packs an 8-bit valid/ready byte stream (least-significant byte first) into
// W-bit words; bits beyond W in the final byte are dropped.
module syndrome_stream_host_byte_deserializer #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enable_i,
    input  logic [7:0]   in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] word_o,
    output logic         done_o
);

    localparam int unsigned NBytes = (W + 7) / 8;
    localparam int unsigned CntW   = $clog2(NBytes + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NBytes - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    word_q, word_d;
    logic [W-1:0]    full_word;
    logic            accept, last;

    // Ready depends only on the enable (i.e. the parent's state), never on valid.
    assign in_ready_o = enable_i;
    assign accept     = enable_i & in_valid_i;
    assign last       = (cnt_q == LastCnt);
    assign done_o     = accept & last;
    assign word_o     = word_q;

    if (NBytes > 1) begin : g_stage
        localparam int unsigned StageW = (NBytes - 1) * 8;
        logic [StageW-1:0] stage_q, stage_d;

        always_comb begin
            stage_d = stage_q;
            if (accept && !last) begin
                stage_d = StageW'({in_data_i, stage_q} >> 8);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) stage_q <= '0;
            else         stage_q <= stage_d;
        end

        assign full_word = W'({in_data_i, stage_q});
    end else begin : g_single
        assign full_word = W'(in_data_i);
    end

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (accept) begin
            if (last) begin
                cnt_d  = '0;
                word_d = full_word;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/syndrome_stream_host.sv
// Host endpoint: serialises a decode job (header + measurement rounds) onto the
// controller's byte input and parses its result stream into per-round corrections.
module syndrome_stream_host
    import syndrome_stream_host_pkg::*;
#(
    parameter int unsigned GRID_WIDTH_X = 4,
    parameter int unsigned GRID_WIDTH_Z = 1,
    parameter int unsigned GRID_WIDTH_U = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_cmd,
    input  logic                  job_start,
    output logic                  busy,
    syndrome_stream_host_if.master bus
);

    localparam int unsigned BYTES_PER_ROUND      = ceil_div8(GRID_WIDTH_X * GRID_WIDTH_Z);
    localparam int unsigned ALIGNED_PU_PER_ROUND = 8 * BYTES_PER_ROUND;
    localparam int unsigned MEAS_ROUNDS          = GRID_WIDTH_U / 2;
    localparam int unsigned CORR_WIDTH           = corr_width(GRID_WIDTH_X, GRID_WIDTH_Z);
    localparam int unsigned BYTE_CNT_W           = $clog2(BYTES_PER_ROUND + 1);
    localparam int unsigned ROUND_CNT_W          = $clog2(MEAS_ROUNDS + 1);

    localparam logic [BYTE_CNT_W-1:0]  LAST_BYTE  = BYTE_CNT_W'(BYTES_PER_ROUND - 1);
    localparam logic [ROUND_CNT_W-1:0] LAST_ROUND = ROUND_CNT_W'(MEAS_ROUNDS - 1);

    logic [2:0]                      state_q, state_d;
    logic [7:0]                      tx_data_q, tx_data_d;
    logic                            tx_valid_q, tx_valid_d;
    logic [ALIGNED_PU_PER_ROUND-1:0] shreg_q, shreg_d;
    logic [BYTE_CNT_W-1:0]           byte_cnt_q, byte_cnt_d;
    logic [ROUND_CNT_W-1:0]          round_cnt_q, round_cnt_d;
    logic [ROUND_CNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic [1:0]                      hdr_cnt_q, hdr_cnt_d;
    logic [7:0]                      iter_q, iter_d;
    logic [15:0]                     cycles_q, cycles_d;

    logic tx_accept;
    logic meas_ready, hdr_ready, corr_ready, corr_done;
    logic res_valid, res_last;

    assign tx_accept = tx_valid_q & bus.tx_ready;

    syndrome_stream_host_byte_deserializer #(
        .W (CORR_WIDTH)
    ) u_corr_deser (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .enable_i   (state_q == ST_RECV_CORR),
        .in_data_i  (bus.rx_data),
        .in_valid_i (bus.rx_valid),
        .in_ready_o (corr_ready),
        .word_o     (bus.res_correction),
        .done_o     (corr_done)
    );

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        shreg_d     = shreg_q;
        byte_cnt_d  = byte_cnt_q;
        round_cnt_d = round_cnt_q;
        word_cnt_d  = word_cnt_q;
        hdr_cnt_d   = hdr_cnt_q;
        iter_d      = iter_q;
        cycles_d    = cycles_q;
        meas_ready  = 1'b0;
        hdr_ready   = 1'b0;
        res_valid   = 1'b0;
        res_last    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start_cmd has priority; a simultaneous job_start is dropped.
                if (start_cmd) begin
                    state_d    = ST_SEND_START;
                    tx_data_d  = START_DECODING_MSG;
                    tx_valid_d = 1'b1;
                end else if (job_start) begin
                    state_d    = ST_SEND_HEADER;
                    tx_data_d  = MEASUREMENT_DATA_HEADER;
                    tx_valid_d = 1'b1;
                end
            end
            ST_SEND_START: begin
                if (tx_accept) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_SEND_HEADER: begin
                if (tx_accept) begin
                    tx_valid_d  = 1'b0;
                    round_cnt_d = '0;
                    state_d     = ST_LOAD_ROUND;
                end
            end
            ST_LOAD_ROUND: begin
                meas_ready = 1'b1;
                if (bus.meas_valid) begin
                    shreg_d    = bus.meas_data;
                    tx_data_d  = bus.meas_data[7:0];
                    tx_valid_d = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = ST_SEND_ROUND;
                end
            end
            ST_SEND_ROUND: begin
                if (tx_accept) begin
                    shreg_d    = shreg_q >> 8;
                    tx_data_d  = shreg_d[7:0];
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    if (byte_cnt_q == LAST_BYTE) begin
                        tx_valid_d  = 1'b0;
                        round_cnt_d = round_cnt_q + ROUND_CNT_W'(1);
                        hdr_cnt_d   = '0;
                        state_d     = (round_cnt_q == LAST_ROUND) ? ST_RECV_HDR : ST_LOAD_ROUND;
                    end
                end
            end
            ST_RECV_HDR: begin
                hdr_ready = 1'b1;
                if (bus.rx_valid) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    unique case (hdr_cnt_q)
                        2'd0: iter_d = bus.rx_data;
                        2'd1: cycles_d[15:8] = bus.rx_data;
                        default: begin
                            cycles_d[7:0] = bus.rx_data;
                            word_cnt_d    = '0;
                            state_d       = ST_RECV_CORR;
                        end
                    endcase
                end
            end
            ST_RECV_CORR: begin
                if (corr_done) state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                res_valid = 1'b1;
                res_last  = (word_cnt_q == LAST_ROUND);
                if (bus.res_ready) begin
                    if (res_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + ROUND_CNT_W'(1);
                        state_d    = ST_RECV_CORR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            shreg_q     <= '0;
            byte_cnt_q  <= '0;
            round_cnt_q <= '0;
            word_cnt_q  <= '0;
            hdr_cnt_q   <= '0;
            iter_q      <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            shreg_q     <= shreg_d;
            byte_cnt_q  <= byte_cnt_d;
            round_cnt_q <= round_cnt_d;
            word_cnt_q  <= word_cnt_d;
            hdr_cnt_q   <= hdr_cnt_d;
            iter_q      <= iter_d;
            cycles_q    <= cycles_d;
        end
    end

    assign bus.tx_data        = tx_data_q;
    assign bus.tx_valid       = tx_valid_q;
    assign bus.meas_ready     = meas_ready;
    assign bus.rx_ready       = hdr_ready | corr_ready;
    assign bus.res_iterations = iter_q;
    assign bus.res_cycles     = cycles_q;
    assign bus.res_valid      = res_valid;
    assign bus.res_last       = res_last;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_syndrome_stream_host.sv
// Scoreboard bench for syndrome_stream_host: stimulus pushes expected tx bytes and
// result words into queues; monitors pop and compare on each handshake.
module tb_syndrome_stream_host;
    import syndrome_stream_host_pkg::*;

    localparam int unsigned MEAS_W = 8;
    localparam int unsigned CORR_W = 11;

    typedef struct {
        logic [CORR_W-1:0] corr;
        logic              last;
        logic [7:0]        iter;
        logic [15:0]       cyc;
    } res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_cmd = 1'b0;
    logic job_start = 1'b0;
    logic busy;
    logic tx_rand = 1'b0;
    logic tx_fix = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    res_t       res_q[$];

    logic       stall_seen = 1'b0;
    logic [7:0] stall_data = '0;

    syndrome_stream_host_if #(.MEAS_W(MEAS_W), .CORR_W(CORR_W)) bus ();

    syndrome_stream_host #(
        .GRID_WIDTH_X (4),
        .GRID_WIDTH_Z (1),
        .GRID_WIDTH_U (5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_cmd (start_cmd),
        .job_start (job_start),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // tx_ready is driven only here, mid-cycle, so negedge samples see a stable value.
    always @(posedge clk) begin
        #2;
        bus.tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : tx_fix;
    end

    always @(negedge clk) begin
        if (reset_n && bus.tx_valid) begin
            if (stall_seen) check("tx_stall_hold", {24'd0, bus.tx_data}, {24'd0, stall_data});
            if (bus.tx_ready) begin
                stall_seen = 1'b0;
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got 0x%0h, required no byte", bus.tx_data);
                end else begin
                    check("tx_byte", {24'd0, bus.tx_data}, {24'd0, tx_q.pop_front()});
                end
            end else begin
                stall_seen = 1'b1;
                stall_data = bus.tx_data;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n && bus.res_valid && bus.res_ready) begin
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: got 0x%0h, required no word", bus.res_correction);
            end else begin
                res_t e;
                e = res_q.pop_front();
                check("res_correction", 32'(bus.res_correction), 32'(e.corr));
                check("res_last", 32'(bus.res_last), 32'(e.last));
                check("res_iterations", 32'(bus.res_iterations), 32'(e.iter));
                check("res_cycles", 32'(bus.res_cycles), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_round(input logic [7:0] d);
        int n = 0;
        bus.meas_data  = d;
        bus.meas_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.meas_ready && n < 300);
        if (!bus.meas_ready) begin
            checks++;
            errors++;
            $display("FAIL meas_timeout: got meas_ready=0, required 1");
        end
        tick();
        bus.meas_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rx_ready && n < 300);
        if (!bus.rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: got rx_ready=0, required 1");
        end
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_rx_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rx_ready && n < 300);
        check("tx_valid_after_send", 32'(bus.tx_valid), 32'd0);
        check("rx_ready_after_send", 32'(bus.rx_ready), 32'd1);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_res_queue"}, 32'(res_q.size()), 32'd0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_meas_ready"}, 32'(bus.meas_ready), 32'd0);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_res_last"}, 32'(bus.res_last), 32'd0);
        check({tag, "_res_iter"}, 32'(bus.res_iterations), 32'd0);
        check({tag, "_res_cycles"}, 32'(bus.res_cycles), 32'd0);
        check({tag, "_res_corr"}, 32'(bus.res_correction), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic push_job();
        res_t r;
        tx_q.push_back(MEASUREMENT_DATA_HEADER);
        tx_q.push_back(8'h0A);
        tx_q.push_back(8'h05);
        r.iter = 8'h03; r.cyc = 16'h012C;
        r.corr = 11'h534; r.last = 1'b0;
        res_q.push_back(r);
        r.corr = 11'h712; r.last = 1'b1;
        res_q.push_back(r);
    endtask

    task automatic pulse_job();
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
    endtask

    task automatic run_job(input logic rand_tx, input string tag);
        push_job();
        tx_rand = rand_tx;
        pulse_job();
        send_round(8'h0A);
        send_round(8'h05);
        wait_rx_ready();
        tx_rand = 1'b0;
        send_rx(8'h03);
        send_rx(8'h01);
        send_rx(8'h2C);
        send_rx(8'h34);
        send_rx(8'h05);
        send_rx(8'h12);
        send_rx(8'h07);
        wait_idle(tag);
    endtask

    initial begin
        bus.meas_data  = '0;
        bus.meas_valid = 1'b0;
        bus.rx_data    = '0;
        bus.rx_valid   = 1'b0;
        bus.res_ready  = 1'b1;
        bus.tx_ready   = 1'b1;

        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        run_job(1'b0, "basic");
        run_job(1'b1, "tx_stall");

        // Consumer back-pressure: word and rx side must freeze while res_ready is low.
        push_job();
        pulse_job();
        send_round(8'h0A);
        send_round(8'h05);
        wait_rx_ready();
        bus.res_ready = 1'b0;
        send_rx(8'h03);
        send_rx(8'h01);
        send_rx(8'h2C);
        send_rx(8'h34);
        send_rx(8'h05);
        bus.rx_data  = 8'h12;
        bus.rx_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("hold_rx_ready", 32'(bus.rx_ready), 32'd0);
            check("hold_res_valid", 32'(bus.res_valid), 32'd1);
            check("hold_res_corr", 32'(bus.res_correction), 32'h534);
        end
        tick();
        bus.res_ready = 1'b1;
        send_rx(8'h12);
        send_rx(8'h07);
        wait_idle("backpressure");

        // Reset mid SEND_ROUND aborts the job; the next job starts with the header again.
        tx_q.push_back(MEASUREMENT_DATA_HEADER);
        pulse_job();
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.meas_ready && n < 300);
        end
        tick();
        tx_fix = 1'b0;
        send_round(8'h0A);
        @(negedge clk);
        check("pre_reset_tx_valid", 32'(bus.tx_valid), 32'd1);
        check("pre_reset_tx_data", 32'(bus.tx_data), 32'h0A);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        tick();
        tick();
        reset_n = 1'b1;
        tx_fix  = 1'b1;
        tick();
        check("abort_tx_queue", 32'(tx_q.size()), 32'd0);
        run_job(1'b0, "after_reset");

        // start_cmd beats a simultaneous job_start: one START byte, no header.
        tx_q.push_back(START_DECODING_MSG);
        start_cmd = 1'b1;
        job_start = 1'b1;
        tick();
        start_cmd = 1'b0;
        job_start = 1'b0;
        repeat (10) tick();
        check("start_busy", 32'(busy), 32'd0);
        check("start_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("start_tx_queue", 32'(tx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
